// File: rtl/sat_problem_loader_if.sv
// Load-side bundle between the problem loader, its staging memory and the WalkSAT controller.
// master = loader, slave = the surrounding memory/controller/host.
interface sat_problem_loader_if #(
    parameter int unsigned NSAT                      = 3,
    parameter int unsigned NUM_VARIABLES             = 2048,
    parameter int unsigned MAX_CLAUSE_MEMBERSHIP     = 20,
    parameter int unsigned UNSAT_CLAUSE_BUFFER_DEPTH = 2048
);
    localparam int unsigned VAW       = $clog2(NUM_VARIABLES);
    localparam int unsigned LAW       = VAW + 1;
    localparam int unsigned UCB_AW    = $clog2(UNSAT_CLAUSE_BUFFER_DEPTH);
    localparam int unsigned CT_WIDTH  = LAW * (NSAT - 1) * MAX_CLAUSE_MEMBERSHIP;
    localparam int unsigned ATT_WIDTH = VAW + MAX_CLAUSE_MEMBERSHIP;
    localparam int unsigned UCB_WIDTH = NSAT * LAW;

    logic                 go_i;
    logic [LAW+1:0]       att_count_i;
    logic [VAW:0]         ct_count_i;
    logic [UCB_AW:0]      ucb_count_i;
    logic                 busy_o;
    logic                 src_rd_en_o;
    logic [1:0]           src_sel_o;
    logic [LAW:0]         src_addr_o;
    logic [ATT_WIDTH-1:0] src_att_data_i;
    logic [CT_WIDTH-1:0]  src_ct_data_i;
    logic [UCB_WIDTH-1:0] src_ucb_data_i;
    logic                 start_o;
    logic [LAW:0]         att_load_addr_o;
    logic [ATT_WIDTH-1:0] att_load_data_o;
    logic                 att_load_valid_o;
    logic [VAW-1:0]       ct_load_addr_o;
    logic [CT_WIDTH-1:0]  ct_load_data_o;
    logic                 ct_load_valid_o;
    logic [UCB_AW-1:0]    ucb_load_addr_o;
    logic [UCB_WIDTH-1:0] ucb_load_data_o;
    logic                 ucb_load_valid_o;
    logic                 ctrl_done_i;
    logic                 result_valid_o;
    logic [31:0]          solve_cycles_o;

    modport master (
        input  go_i, att_count_i, ct_count_i, ucb_count_i,
        input  src_att_data_i, src_ct_data_i, src_ucb_data_i, ctrl_done_i,
        output busy_o, src_rd_en_o, src_sel_o, src_addr_o, start_o,
        output att_load_addr_o, att_load_data_o, att_load_valid_o,
        output ct_load_addr_o, ct_load_data_o, ct_load_valid_o,
        output ucb_load_addr_o, ucb_load_data_o, ucb_load_valid_o,
        output result_valid_o, solve_cycles_o
    );

    modport slave (
        output go_i, att_count_i, ct_count_i, ucb_count_i,
        output src_att_data_i, src_ct_data_i, src_ucb_data_i, ctrl_done_i,
        input  busy_o, src_rd_en_o, src_sel_o, src_addr_o, start_o,
        input  att_load_addr_o, att_load_data_o, att_load_valid_o,
        input  ct_load_addr_o, ct_load_data_o, ct_load_valid_o,
        input  ucb_load_addr_o, ucb_load_data_o, ucb_load_valid_o,
        input  result_valid_o, solve_cycles_o
    );
endinterface

// File: rtl/sat_problem_loader.sv
// Pulses the WalkSAT controller start, streams ATT/CT/UCB images as one gapless beat train,
// then measures the solve time until the controller reports done.
module sat_problem_loader #(
    parameter int unsigned NSAT                      = 3,
    parameter int unsigned NUM_VARIABLES             = 2048,
    parameter int unsigned MAX_CLAUSE_MEMBERSHIP     = 20,
    parameter int unsigned UNSAT_CLAUSE_BUFFER_DEPTH = 2048
) (
    input logic                  clk,
    input logic                  rst,
    sat_problem_loader_if.master bus
);
    localparam int unsigned VAW       = $clog2(NUM_VARIABLES);
    localparam int unsigned LAW       = VAW + 1;
    localparam int unsigned UCB_AW    = $clog2(UNSAT_CLAUSE_BUFFER_DEPTH);
    localparam int unsigned ATT_DEPTH = 2 ** (LAW + 1);

    typedef enum logic [2:0] {StIdle, StStart, StStream, StWaitSolve, StReport} state_e;

    state_e       state_q, state_d;
    logic [31:0]  att_n_q, ct_n_q, ucb_n_q;
    logic [31:0]  remaining_q;
    logic [1:0]   phase_q;
    logic [LAW:0] idx_q;
    logic         att_v_q, ct_v_q, ucb_v_q;
    logic [LAW:0] beat_addr_q;
    logic         done_q;
    logic [31:0]  cnt_q;
    logic [31:0]  solve_cycles_q;

    logic [31:0]  att_c, ct_c, ucb_c;
    logic [31:0]  cur_n;
    logic         issue, last_in_phase, done_edge, go_accept;
    logic [1:0]   next_phase;

    always_comb begin
        att_c = 32'(bus.att_count_i);
        ct_c  = 32'(bus.ct_count_i);
        ucb_c = 32'(bus.ucb_count_i);
        if (att_c > ATT_DEPTH) att_c = ATT_DEPTH;
        if (ct_c > NUM_VARIABLES) ct_c = NUM_VARIABLES;
        if (ucb_c > UNSAT_CLAUSE_BUFFER_DEPTH) ucb_c = UNSAT_CLAUSE_BUFFER_DEPTH;
    end

    always_comb begin
        cur_n = ucb_n_q;
        if (phase_q == 2'd0) cur_n = att_n_q;
        else if (phase_q == 2'd1) cur_n = ct_n_q;
    end

    assign go_accept     = (state_q == StIdle) && bus.go_i;
    assign issue         = ((state_q == StStart) || (state_q == StStream)) && (remaining_q != 32'd0);
    assign last_in_phase = (32'(idx_q) + 32'd1) == cur_n;
    // Empty CT image falls straight through to UCB so the beat train stays gapless.
    assign next_phase    = ((phase_q == 2'd0) && (ct_n_q != 32'd0)) ? 2'd1 : 2'd2;
    // A done level carried over from an earlier run must not end this one.
    assign done_edge     = bus.ctrl_done_i && !done_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (bus.go_i) state_d = StStart;
            StStart:     state_d = (remaining_q == 32'd0) ? StWaitSolve : StStream;
            StStream:    if (remaining_q == 32'd0) state_d = StWaitSolve;
            StWaitSolve: if (done_edge) state_d = StReport;
            StReport:    state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy_o           = (state_q != StIdle);
        bus.start_o          = (state_q == StStart);
        bus.result_valid_o   = (state_q == StReport);
        bus.solve_cycles_o   = solve_cycles_q;
        bus.src_rd_en_o      = issue;
        bus.src_sel_o        = issue ? phase_q : 2'd0;
        bus.src_addr_o       = issue ? idx_q : '0;
        bus.att_load_valid_o = att_v_q;
        bus.ct_load_valid_o  = ct_v_q;
        bus.ucb_load_valid_o = ucb_v_q;
        bus.att_load_addr_o  = att_v_q ? beat_addr_q : '0;
        bus.ct_load_addr_o   = ct_v_q ? beat_addr_q[VAW-1:0] : '0;
        bus.ucb_load_addr_o  = ucb_v_q ? beat_addr_q[UCB_AW-1:0] : '0;
        bus.att_load_data_o  = att_v_q ? bus.src_att_data_i : '0;
        bus.ct_load_data_o   = ct_v_q ? bus.src_ct_data_i : '0;
        bus.ucb_load_data_o  = ucb_v_q ? bus.src_ucb_data_i : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            att_n_q        <= '0;
            ct_n_q         <= '0;
            ucb_n_q        <= '0;
            remaining_q    <= '0;
            phase_q        <= '0;
            idx_q          <= '0;
            att_v_q        <= 1'b0;
            ct_v_q         <= 1'b0;
            ucb_v_q        <= 1'b0;
            beat_addr_q    <= '0;
            done_q         <= 1'b0;
            cnt_q          <= '0;
            solve_cycles_q <= '0;
        end else begin
            done_q      <= bus.ctrl_done_i;
            att_v_q     <= issue && (phase_q == 2'd0);
            ct_v_q      <= issue && (phase_q == 2'd1);
            ucb_v_q     <= issue && (phase_q == 2'd2);
            beat_addr_q <= issue ? idx_q : '0;

            if (go_accept) begin
                att_n_q        <= att_c;
                ct_n_q         <= ct_c;
                ucb_n_q        <= ucb_c;
                remaining_q    <= att_c + ct_c + ucb_c;
                phase_q        <= (att_c != 32'd0) ? 2'd0 : ((ct_c != 32'd0) ? 2'd1 : 2'd2);
                idx_q          <= '0;
                solve_cycles_q <= '0;
            end else if (issue) begin
                remaining_q <= remaining_q - 32'd1;
                if (last_in_phase) begin
                    idx_q   <= '0;
                    phase_q <= next_phase;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end

            if (state_q == StStart) begin
                cnt_q <= '0;
            end else if (((state_q == StStream) || (state_q == StWaitSolve)) &&
                         (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end

            if ((state_q == StWaitSolve) && done_edge) solve_cycles_q <= cnt_q;
        end
    end
endmodule

// File: tb/tb_sat_problem_loader.sv
// Directed bench for sat_problem_loader: a staging-memory model answers reads, and a scoreboard
// of expected beats (table, address, data, cycle offset from start) is checked every cycle.
module tb_sat_problem_loader;
    localparam int unsigned NSAT  = 3;
    localparam int unsigned NV    = 16;
    localparam int unsigned MCM   = 2;
    localparam int unsigned UCBD  = 16;
    localparam int unsigned ATT_W = 6;
    localparam int unsigned CT_W  = 20;
    localparam int unsigned UCB_W = 15;
    localparam int          ATT_DEPTH = 64;

    typedef struct {
        int          tbl;
        int          addr;
        logic [63:0] data;
        int          offs;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    t_start = 0;
    int    n;

    always #5 clk = ~clk;

    sat_problem_loader_if #(
        .NSAT(NSAT), .NUM_VARIABLES(NV), .MAX_CLAUSE_MEMBERSHIP(MCM),
        .UNSAT_CLAUSE_BUFFER_DEPTH(UCBD)
    ) bus ();

    sat_problem_loader #(
        .NSAT(NSAT), .NUM_VARIABLES(NV), .MAX_CLAUSE_MEMBERSHIP(MCM),
        .UNSAT_CLAUSE_BUFFER_DEPTH(UCBD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [63:0] word(input int tbl, input int addr);
        logic [ATT_W-1:0] a;
        logic [CT_W-1:0]  c;
        logic [UCB_W-1:0] u;
        a = ATT_W'(addr * 7 + 1);
        c = 20'hA5000 ^ CT_W'(addr);
        u = 15'h1200 + UCB_W'(addr);
        case (tbl)
            0:       return 64'(a);
            1:       return 64'(c);
            default: return 64'(u);
        endcase
    endfunction

    // Staging memory: one-cycle read latency, all three buses answer every read.
    always @(posedge clk) begin
        if (bus.src_rd_en_o) begin
            bus.src_att_data_i <= ATT_W'(word(0, int'(bus.src_addr_o)));
            bus.src_ct_data_i  <= CT_W'(word(1, int'(bus.src_addr_o)));
            bus.src_ucb_data_i <= UCB_W'(word(2, int'(bus.src_addr_o)));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int          nv;
        int          tbl;
        logic [63:0] a;
        logic [63:0] d;
        logic        stray;
        beat_t       e;
        @(posedge clk);
        #1;
        cyc++;
        nv = int'(bus.att_load_valid_o) + int'(bus.ct_load_valid_o) + int'(bus.ucb_load_valid_o);
        check("valid_onehot", 64'(nv <= 1), 64'(1));
        stray = (!bus.att_load_valid_o && ((|bus.att_load_data_o) || (|bus.att_load_addr_o))) ||
                (!bus.ct_load_valid_o && ((|bus.ct_load_data_o) || (|bus.ct_load_addr_o))) ||
                (!bus.ucb_load_valid_o && ((|bus.ucb_load_data_o) || (|bus.ucb_load_addr_o)));
        check("idle_beat_gated", 64'(stray), 64'(0));
        if (nv == 1) begin
            tbl = bus.att_load_valid_o ? 0 : (bus.ct_load_valid_o ? 1 : 2);
            case (tbl)
                0:       begin a = 64'(bus.att_load_addr_o); d = 64'(bus.att_load_data_o); end
                1:       begin a = 64'(bus.ct_load_addr_o);  d = 64'(bus.ct_load_data_o);  end
                default: begin a = 64'(bus.ucb_load_addr_o); d = 64'(bus.ucb_load_data_o); end
            endcase
            if (sb.size() == 0) begin
                check("beat_expected", 64'(sb.size()), 64'(1));
            end else begin
                e = sb.pop_front();
                check("beat_table", 64'(tbl), 64'(e.tbl));
                check("beat_addr", a, 64'(e.addr));
                check("beat_data", d, e.data);
                check("beat_cycle", 64'(cyc - t_start), 64'(e.offs));
            end
        end
    endtask

    task automatic start_go(input int att, input int ct, input int ucb, output int total);
        int na, nc, nu, k;
        na = (att > ATT_DEPTH) ? ATT_DEPTH : att;
        nc = (ct > int'(NV)) ? int'(NV) : ct;
        nu = (ucb > int'(UCBD)) ? int'(UCBD) : ucb;
        k  = 1;
        for (int i = 0; i < na; i++) begin sb.push_back('{0, i, word(0, i), k}); k++; end
        for (int i = 0; i < nc; i++) begin sb.push_back('{1, i, word(1, i), k}); k++; end
        for (int i = 0; i < nu; i++) begin sb.push_back('{2, i, word(2, i), k}); k++; end
        total = na + nc + nu;
        bus.att_count_i = 7'(att);
        bus.ct_count_i  = 5'(ct);
        bus.ucb_count_i = 5'(ucb);
        bus.go_i = 1'b1;
        step();
        bus.go_i = 1'b0;
        t_start = cyc;
        check("start_pulse", 64'(bus.start_o), 64'(1));
        check("busy_in_start", 64'(bus.busy_o), 64'(1));
        check("first_read", 64'(bus.src_rd_en_o), 64'(total != 0));
    endtask

    task automatic run_load(input int att, input int ct, input int ucb, input logic go_mid);
        int total;
        start_go(att, ct, ucb, total);
        bus.go_i = go_mid;
        repeat (total + 1) step();
        bus.go_i = 1'b0;
        check("all_beats_delivered", 64'(sb.size()), 64'(0));
        check("busy_after_stream", 64'(bus.busy_o), 64'(1));
        check("no_read_after_stream", 64'(bus.src_rd_en_o), 64'(0));
    endtask

    task automatic raise_done_and_report(input int d, input logic [31:0] exp);
        logic got;
        repeat (d) step();
        bus.ctrl_done_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = bus.result_valid_o;
        end
        check("result_pulse", 64'(got), 64'(1));
        check("solve_cycles", 64'(bus.solve_cycles_o), 64'(exp));
    endtask

    task automatic after_report(input logic [31:0] exp);
        step();
        check("result_one_cycle", 64'(bus.result_valid_o), 64'(0));
        check("solve_cycles_hold", 64'(bus.solve_cycles_o), 64'(exp));
        check("idle_after_report", 64'(bus.busy_o), 64'(0));
    endtask

    initial begin
        bus.go_i        = 1'b0;
        bus.att_count_i = '0;
        bus.ct_count_i  = '0;
        bus.ucb_count_i = '0;
        bus.ctrl_done_i = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        check("rst_busy", 64'(bus.busy_o), 64'(0));
        check("rst_start", 64'(bus.start_o), 64'(0));
        check("rst_rd_en", 64'(bus.src_rd_en_o), 64'(0));
        check("rst_sel_addr", 64'({bus.src_sel_o, bus.src_addr_o}), 64'(0));
        check("rst_result", 64'(bus.result_valid_o), 64'(0));
        check("rst_solve_cycles", 64'(bus.solve_cycles_o), 64'(0));
        rst = 1'b0;
        step();

        // ATT 3, CT 2, UCB 1 back to back; done seen two cycles into WAIT_SOLVE.
        run_load(3, 2, 1, 1'b0);
        raise_done_and_report(2, 32'd8);
        after_report(32'd8);

        // Empty CT phase skipped; done still high from the previous run must be ignored.
        run_load(2, 0, 2, 1'b0);
        repeat (6) step();
        check("held_done_ignored", 64'(bus.busy_o), 64'(1));
        check("held_done_no_result", 64'(bus.result_valid_o), 64'(0));
        bus.ctrl_done_i = 1'b0;
        raise_done_and_report(1, 32'd11);
        after_report(32'd11);
        bus.ctrl_done_i = 1'b0;
        step();

        // All counts zero: start pulse only, done five cycles into WAIT_SOLVE.
        run_load(0, 0, 0, 1'b0);
        raise_done_and_report(5, 32'd5);
        after_report(32'd5);
        bus.ctrl_done_i = 1'b0;
        step();

        // Reset during the CT phase aborts; a new go restarts at ATT address 0.
        start_go(2, 3, 1, n);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("abort_busy", 64'(bus.busy_o), 64'(0));
        check("abort_valids",
              64'({bus.att_load_valid_o, bus.ct_load_valid_o, bus.ucb_load_valid_o}), 64'(0));
        check("abort_rd_en", 64'(bus.src_rd_en_o), 64'(0));
        check("abort_start", 64'(bus.start_o), 64'(0));
        sb.delete();
        rst = 1'b0;
        step();
        run_load(2, 1, 0, 1'b0);
        raise_done_and_report(0, 32'd3);
        after_report(32'd3);
        bus.ctrl_done_i = 1'b0;
        step();

        // Oversized ATT count clamps to 64 beats ending at address 63; go held during STREAM.
        run_load(70, 0, 0, 1'b1);
        raise_done_and_report(0, 32'd64);
        after_report(32'd64);
        bus.ctrl_done_i = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
